// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry elastic pipeline register with registered ready
//
// Purpose:
//   Decouples a producing stage from a consuming stage. There are two storage registers.
//   The main register is the head and drives out_data_o. The skid register holds a
//   second entry. in_ready_o and out_valid_o are decoded from the state register only.
//   As a result, downstream back-pressure never reaches upstream combinationally.
//
// Optional feature (macro PIPE_SKID_BUFFER_STATS_EN):
//   Adds stall_cnt_o. This saturating counter counts cycles where out_valid_o = 1 and
//   out_ready_i = 0. It is cleared by reset_n and is not affected by flush_i.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_n      asynchronous active-low reset
//   flush_i      synchronous flush, drops all held entries
//   in_valid_i   upstream payload valid
//   in_data_i    upstream payload
//   in_ready_o   buffer can accept a payload this cycle
//   out_valid_o  out_data_o holds a valid payload
//   out_data_o   oldest held payload
//   out_ready_i  downstream accepts the payload this cycle
//   stall_cnt_o  stall cycle counter (PIPE_SKID_BUFFER_STATS_EN only)

module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
`ifdef PIPE_SKID_BUFFER_STATS_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic             in_fire;
    logic             out_fire;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush_i) begin
            // A payload offered in the flush cycle is dropped, so no loads happen.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = HALF;
                        main_load = 1'b1;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready_o is low here, so only the drain path exists.
                    if (out_fire) begin
                        state_d        = HALF;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // The data registers are enabled only on load, so they stay quiet while idle.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load) begin
                main_q <= main_from_skid ? skid_q : in_data_i;
            end
            if (skid_load) begin
                skid_q <= in_data_i;
            end
        end
    end

`ifdef PIPE_SKID_BUFFER_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb/tb_pipe_skid_buffer.sv - directed self-checking bench for pipe_skid_buffer

module tb_pipe_skid_buffer;

    localparam int WIDTH = 32;

    logic             clk_i;
    logic             reset_n;
    logic             flush_i;
    logic             in_valid_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_ready_i;
`ifdef PIPE_SKID_BUFFER_STATS_EN
    logic [31:0]      stall_cnt_o;
`endif

    int checks;
    int errors;

    pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i)
`ifdef PIPE_SKID_BUFFER_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge, then settle 1 time unit before sampling or driving.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #3;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b expected 1", in_ready_o);
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b expected 0", out_valid_o);
        end
        checks++;
        if (out_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data got %h expected 0", out_data_o);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        logic [WIDTH-1:0] exp_data [3];
        exp_data[0] = 32'd1;
        exp_data[1] = 32'd2;
        exp_data[2] = 32'd3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, exp_data[i], 1'b1, 1'b0);
            tick();
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_data[i]) begin
                errors++;
                $display("FAIL pass_data[%0d] got v=%0b d=%h expected v=1 d=%h", i, out_valid_o, out_data_o, exp_data[i]);
            end
            checks++;
            if (in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL pass_in_ready[%0d] got %0b expected 1", i, in_ready_o);
            end
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_drain got %0b expected 0", out_valid_o);
        end
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hA || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got v=%0b d=%h r=%0b expected v=1 d=a r=1", out_valid_o, out_data_o, in_ready_o);
        end
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        tick();
        checks++;
        if (in_ready_o !== 1'b0 || out_data_o !== 32'hA) begin
            errors++;
            $display("FAIL bp_full got r=%0b d=%h expected r=0 d=a", in_ready_o, out_data_o);
        end
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== 32'hA) begin
            errors++;
            $display("FAIL bp_hold got r=%0b v=%0b d=%h expected r=0 v=1 d=a", in_ready_o, out_valid_o, out_data_o);
        end
        drive(1'b0, 32'hDEAD, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hB || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_b got v=%0b d=%h r=%0b expected v=1 d=b r=1", out_valid_o, out_data_o, in_ready_o);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain_empty got v=%0b d=%h expected v=0 (0xc dropped)", out_valid_o, out_data_o);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h6, 1'b0, 1'b0);
        tick();
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_prefull got r=%0b expected 0", in_ready_o);
        end
        drive(1'b1, 32'h7, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got v=%0b r=%0b expected v=0 r=1", out_valid_o, in_ready_o);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_7[%0d] got v=%0b d=%h expected v=0", i, out_valid_o, out_data_o);
            end
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h11 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_half got v=%0b d=%h r=%0b expected v=1 d=11 r=1", out_valid_o, out_data_o, in_ready_o);
        end
        // Idle with toggling data while invalid: nothing may appear.
        drive(1'b0, 32'h99, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h77, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL idle got v=%0b r=%0b expected v=0 r=1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset_full();
        drive(1'b1, 32'h21, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got r=%0b v=%0b d=%h expected r=1 v=0 d=0", in_ready_o, out_valid_o, out_data_o);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

`ifdef PIPE_SKID_BUFFER_STATS_EN
    task automatic test_stats();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        checks++;
        if (stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset got %0d expected 0", stall_cnt_o);
        end
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cnt_o !== 32'd5) begin
            errors++;
            $display("FAIL stats_count got %0d expected 5", stall_cnt_o);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (stall_cnt_o !== 32'd5) begin
            errors++;
            $display("FAIL stats_flush got %0d expected 5", stall_cnt_o);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_simultaneous();
        test_reset_full();
`ifdef PIPE_SKID_BUFFER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Two-entry elastic pipeline register with valid/ready handshakes on both sides.
- Decouples a producing stage from a consuming stage. The consumer's back-pressure has no combinational path to the producer.
- Sits between CPU pipeline stages, or between the fetch unit and the instruction queue.
- Synchronous flush drops all held data on branch mispredict or trap.

Parameters:
- WIDTH, 32, payload width in bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all held entries.
- in_valid_i  input  1  upstream payload valid.
- in_data_i  input  WIDTH  upstream payload.
- in_ready_o  output  1  buffer can accept a payload this cycle.
- out_valid_o  output  1  out_data_o holds a valid payload.
- out_data_o  output  WIDTH  oldest held payload.
- out_ready_i  input  1  downstream accepts the payload this cycle.

Behaviour:
- Clocking and reset: one clock, clk_i. reset_n is asynchronous and active-low.
- Storage: main register (head, drives out_data_o) and skid register (second entry).
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- State register:
  - States: EMPTY (0 entries), HALF (main full), FULL (main and skid full).
  - Outputs decoded from state only: in_ready_o = (state != FULL); out_valid_o = (state != EMPTY).
  - No combinational path from out_ready_i to in_ready_o, or from in_valid_i to out_valid_o.
- Reset (reset_n low, asynchronous):
  - state = EMPTY, main = 0, skid = 0.
  - Hence in_ready_o = 1, out_valid_o = 0, out_data_o = 0.
  - Reset mid-transfer loses all data immediately. No partial handshake completes.
- Transitions, evaluated at the rising clk_i edge, flush_i = 0:
  - EMPTY: in_fire -> HALF, main <= in_data_i. Otherwise stay.
  - HALF, in_fire & out_fire -> HALF, main <= in_data_i (pass-through, full throughput).
  - HALF, in_fire only -> FULL, skid <= in_data_i.
  - HALF, out_fire only -> EMPTY.
  - HALF, neither -> stay.
  - FULL: out_fire -> HALF, main <= skid. in_fire is impossible because in_ready_o = 0.
- Latency and throughput:
  - A payload accepted at edge N is visible on out_data_o after edge N, i.e. one cycle later.
  - Sustained 1 transfer per cycle when out_ready_i stays high.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Flush (flush_i = 1 at the edge):
  - state <= EMPTY regardless of handshakes. A payload offered in the same cycle is dropped, even if in_ready_o = 1.
  - An out_fire in the same cycle still counts as consumed by downstream.
  - Data registers are not cleared; they are don't-care while out_valid_o = 0.
- Stability: while out_valid_o = 1 and out_ready_i = 0, out_data_o and out_valid_o hold steady until out_fire or flush.
- Idle: with in_valid_i = 0 and no flush, the data registers do not toggle (clock-enable only on load).
- Illegal-input tolerance: in_data_i changing while in_valid_i is low is ignored.

Optional Feature:
- Macro: PIPE_SKID_BUFFER_STATS_EN.
- Defined:
  - Adds output stall_cnt_o (32 bits).
  - Increments once per cycle with out_valid_o = 1 and out_ready_i = 0. Saturates at 32'hFFFF_FFFF.
  - Cleared to 0 by reset_n. Not affected by flush_i.
- Undefined:
  - Port and counter logic absent.
  - All other behaviour identical.

Test Plan:
- Reset: assert reset_n = 0 mid-cycle with the buffer FULL -> immediately in_ready_o = 1, out_valid_o = 0, out_data_o = 0.
- Pass-through: out_ready_i = 1, push 1, 2, 3 on consecutive cycles -> out_data_o = 1, 2, 3 on the following cycles, in_ready_o stays 1.
- Back-pressure fill/drain:
  - out_ready_i = 0, push 0xA then 0xB -> in_ready_o = 0 after the second edge, out_data_o = 0xA held.
  - A third push of 0xC is not accepted.
  - Raise out_ready_i -> outputs 0xA, then 0xB, then out_valid_o = 0.
- Flush:
  - FULL with 0x5, 0x6; assert flush_i with in_valid_i = 1, in_data_i = 0x7 -> next cycle out_valid_o = 0, in_ready_o = 1.
  - 0x7 is never output.
- Simultaneous in/out in HALF: main = 0x10, push 0x11 with out_ready_i = 1 -> state remains HALF, out_data_o = 0x11.
- Stats (PIPE_SKID_BUFFER_STATS_EN):
  - Hold one entry with out_ready_i = 0 for 5 cycles -> stall_cnt_o = 5.
  - A following flush leaves stall_cnt_o = 5.
